// File: rtl/mpc_constraint_check.sv
// Streams the constraint vector h and the product vector gu, forms d = gu - h for each row,
// and reports feasibility, the number of violated rows, and the largest d with its lowest index.
module mpc_constraint_check #(
  parameter int N_CON = 7,
  parameter int DW    = 21,
  parameter int AW    = 5
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [AW-1:0]     h_address0,
  output logic              h_ce0,
  input  logic [DW-1:0]     h_q0,
  output logic [AW-1:0]     gu_address0,
  output logic              gu_ce0,
  input  logic [DW-1:0]     gu_q0,
  output logic              feasible,
  output logic [AW-1:0]     viol_count,
  output logic [DW:0]       max_viol,
  output logic [AW-1:0]     max_idx
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(N_CON - 1);

  state_t               state_q, state_d;
  logic [AW-1:0]        i_q, i_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW-1:0]        row_q, row_d;
  logic                 vld_q, vld_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic signed [DW:0]   max_q, max_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 feasible_q, feasible_d;
  logic [AW-1:0]        viol_count_q, viol_count_d;
  logic [DW:0]          max_viol_q, max_viol_d;
  logic [AW-1:0]        max_idx_q, max_idx_d;
  logic signed [DW:0]   d;

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    addr_d       = addr_q;
    row_d        = row_q;
    vld_d        = 1'b0;
    cnt_d        = cnt_q;
    max_d        = max_q;
    idx_d        = idx_q;
    feasible_d   = feasible_q;
    viol_count_d = viol_count_q;
    max_viol_d   = max_viol_q;
    max_idx_d    = max_idx_q;

    // One extra bit so the difference of two DW-bit signed values cannot wrap.
    d = $signed({gu_q0[DW-1], gu_q0}) - $signed({h_q0[DW-1], h_q0});

    if (vld_q) begin
      if (!d[DW] && (d != '0)) begin
        cnt_d = cnt_q + AW'(1);
      end
      if (d > max_q) begin
        max_d = d;
        idx_d = row_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          cnt_d   = '0;
          max_d   = {1'b1, {DW{1'b0}}};
          idx_d   = '0;
          i_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        vld_d  = 1'b1;
        row_d  = i_q;
        addr_d = i_q;
        if (i_q == LAST_ROW) begin
          state_d = DRAIN;
        end else begin
          i_d = i_q + AW'(1);
        end
      end
      DRAIN: begin
        // Results are loaded here so they are already stable while ap_done is high.
        viol_count_d = cnt_d;
        max_viol_d   = max_d;
        max_idx_d    = idx_d;
        feasible_d   = (cnt_d == '0);
        state_d      = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= IDLE;
      i_q          <= '0;
      addr_q       <= '0;
      row_q        <= '0;
      vld_q        <= 1'b0;
      cnt_q        <= '0;
      max_q        <= '0;
      idx_q        <= '0;
      feasible_q   <= 1'b1;
      viol_count_q <= '0;
      max_viol_q   <= '0;
      max_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      addr_q       <= addr_d;
      row_q        <= row_d;
      vld_q        <= vld_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      idx_q        <= idx_d;
      feasible_q   <= feasible_d;
      viol_count_q <= viol_count_d;
      max_viol_q   <= max_viol_d;
      max_idx_q    <= max_idx_d;
    end
  end

  assign h_ce0       = (state_q == READ);
  assign gu_ce0      = (state_q == READ);
  assign h_address0  = (state_q == READ) ? i_q : addr_q;
  assign gu_address0 = (state_q == READ) ? i_q : addr_q;
  assign ap_done     = (state_q == DONE);
  assign ap_ready    = (state_q == DONE);
  assign ap_idle     = (state_q == IDLE) && !ap_start;
  assign feasible    = feasible_q;
  assign viol_count  = viol_count_q;
  assign max_viol    = max_viol_q;
  assign max_idx     = max_idx_q;

endmodule

// File: tb/tb_mpc_constraint_check.sv
// Directed bench for mpc_constraint_check with behavioural 1-cycle-latency memories for h and gu.
module tb_mpc_constraint_check;
  localparam int N_CON = 7;
  localparam int DW    = 21;
  localparam int AW    = 5;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [AW-1:0]     h_address0;
  logic              h_ce0;
  logic [DW-1:0]     h_q0;
  logic [AW-1:0]     gu_address0;
  logic              gu_ce0;
  logic [DW-1:0]     gu_q0;
  logic              feasible;
  logic [AW-1:0]     viol_count;
  logic [DW:0]       max_viol;
  logic [AW-1:0]     max_idx;

  logic signed [DW-1:0] h_mem  [0:31];
  logic signed [DW-1:0] gu_mem [0:31];

  int n_cmp = 0;
  int n_bad = 0;

  mpc_constraint_check #(.N_CON(N_CON), .DW(DW), .AW(AW)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .h_address0  (h_address0),
    .h_ce0       (h_ce0),
    .h_q0        (h_q0),
    .gu_address0 (gu_address0),
    .gu_ce0      (gu_ce0),
    .gu_q0       (gu_q0),
    .feasible    (feasible),
    .viol_count  (viol_count),
    .max_viol    (max_viol),
    .max_idx     (max_idx)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    if (h_ce0)  h_q0  <= h_mem[h_address0];
    if (gu_ce0) gu_q0 <= gu_mem[gu_address0];
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_base();
    for (int i = 0; i < 32; i++) begin
      h_mem[i]  = 21'sd163840;
      gu_mem[i] = '0;
    end
  endtask

  task automatic check_outputs(input string tag, input longint e_feas, input longint e_cnt,
                               input longint e_max, input longint e_idx);
    chk({tag, "_feasible"},   longint'(feasible), e_feas);
    chk({tag, "_viol_count"}, longint'(viol_count), e_cnt);
    chk({tag, "_max_viol"},   longint'($signed(max_viol)), e_max);
    chk({tag, "_max_idx"},    longint'(max_idx), e_idx);
  endtask

  // Pulses ap_start and follows the run cycle by cycle; cycle 1 is the one after the start edge.
  task automatic run_and_check(input string tag, input longint e_feas, input longint e_cnt,
                               input longint e_max, input longint e_idx);
    int n;
    int ce_cnt;
    int done_at;
    int addr_bad;
    int rdy_ok;
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    n = 0; ce_cnt = 0; done_at = -1; addr_bad = 0; rdy_ok = 0;
    while (n < 30 && done_at < 0) begin
      @(negedge ap_clk);
      n++;
      if (h_ce0 != gu_ce0) addr_bad++;
      if (h_ce0) begin
        if (h_address0 != AW'(ce_cnt) || gu_address0 != AW'(ce_cnt)) addr_bad++;
        ce_cnt++;
      end
      if (ap_done) begin
        done_at = n;
        rdy_ok  = ap_ready ? 1 : 0;
        check_outputs(tag, e_feas, e_cnt, e_max, e_idx);
      end
    end
    chk({tag, "_done_cycle"}, done_at, N_CON + 2);
    chk({tag, "_ready_with_done"}, rdy_ok, 1);
    chk({tag, "_ce_cycles"}, ce_cnt, N_CON);
    chk({tag, "_addr_order"}, addr_bad, 0);
    @(negedge ap_clk);
    chk({tag, "_done_one_cycle"}, longint'(ap_done), 0);
    chk({tag, "_idle_after"}, longint'(ap_idle), 1);
    $display("run %s: done at cycle %0d feasible=%0d viol_count=%0d max_viol=%0d max_idx=%0d",
             tag, done_at, feasible, viol_count, $signed(max_viol), max_idx);
  endtask

  initial begin
    int n;
    int dones;
    int done_at [3];
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    fill_base();
    repeat (3) @(negedge ap_clk);
    chk("rst_done", longint'(ap_done), 0);
    chk("rst_ready", longint'(ap_ready), 0);
    chk("rst_idle", longint'(ap_idle), 1);
    chk("rst_ce", longint'({h_ce0, gu_ce0}), 0);
    chk("rst_addr", longint'({h_address0, gu_address0}), 0);
    check_outputs("rst", 1, 0, 0, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // 1: all rows slack by 163840
    run_and_check("t1_feasible", 1, 0, -163840, 0);

    // 2: one violated row
    fill_base();
    gu_mem[5] = 21'sd200000;
    run_and_check("t2_one_viol", 0, 1, 36160, 5);

    // 3: tie at the maximum, and d = 0 not counted
    fill_base();
    gu_mem[2] = 21'sd163850;
    gu_mem[3] = 21'sd163840;
    gu_mem[4] = 21'sd163850;
    run_and_check("t3_tie", 0, 2, 10, 2);

    // 4: extreme operands need the extra result bit
    fill_base();
    h_mem[6]  = -21'sd1048576;
    gu_mem[6] = 21'sd1048575;
    run_and_check("t4_extreme", 0, 1, 2097151, 6);

    // 5: reset in cycle 4 of a run
    fill_base();
    gu_mem[5] = 21'sd200000;
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    repeat (4) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("t5_rst_ce", longint'(h_ce0 | gu_ce0), 0);
    chk("t5_rst_done", longint'(ap_done), 0);
    chk("t5_rst_idle", longint'(ap_idle), 1);
    check_outputs("t5_rst", 1, 0, 0, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge ap_clk);
      if (ap_done) dones++;
    end
    chk("t5_no_done_after_abort", dones, 0);
    run_and_check("t5_restart", 0, 1, 36160, 5);

    // 6: start held high, toggled inside each run
    fill_base();
    gu_mem[2] = 21'sd163850;
    gu_mem[3] = 21'sd163840;
    gu_mem[4] = 21'sd163850;
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    n = 0; dones = 0;
    while (n < 30) begin
      @(negedge ap_clk);
      n++;
      if (ap_done) begin
        if (dones < 3) done_at[dones] = n;
        dones++;
        check_outputs($sformatf("t6_run%0d", dones), 0, 2, 10, 2);
      end
      if (n == 10) chk("t6_idle_low_with_start", longint'(ap_idle), 0);
      if (n % 10 == 3) ap_start = 1'b0;
      if (n % 10 == 5) ap_start = 1'b1;
      if (n == 30) ap_start = 1'b0;
    end
    chk("t6_done_count", dones, 3);
    if (dones >= 3) begin
      chk("t6_first_done", done_at[0], 9);
      chk("t6_period_a", done_at[1] - done_at[0], 10);
      chk("t6_period_b", done_at[2] - done_at[1], 10);
    end
    $display("run t6_back_to_back: %0d done pulses", dones);
    repeat (12) @(negedge ap_clk);
    chk("t6_idle_end", longint'(ap_idle), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
